// File: rtl/bfly_fft_sched.sv
// bfly_fft_sched: address/strobe sequencer for an in-place radix-2 DIF FFT.
// One operand pair per ce cycle; write-back addresses trail reads by PIPE.
module bfly_fft_sched #(
   parameter int LOG2N  = 3,
   parameter int RD_LAT = 1,
   parameter int BF_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [3:0]       stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             bfly_ce,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);

   localparam int PIPE = RD_LAT + BF_LAT;
   localparam int JW   = LOG2N - 1;
   localparam logic [JW-1:0]    JLAST = '1;
   localparam logic [LOG2N-1:0] ONE   = LOG2N'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           st;
   logic [JW-1:0]    j;
   logic [JW-1:0]    nj;
   logic [3:0]       ns;
   logic [3:0]       sh;
   logic [2:0]       dcnt;
   logic [LOG2N-1:0] jx;
   logic [LOG2N-1:0] span;
   logic [LOG2N-1:0] lo;
   logic [LOG2N-1:0] na;
   logic [LOG2N-1:0] nb;
   logic [JW-1:0]    kk;
   logic [JW-1:0]    ntw;

   logic [PIPE-1:0]  vq;
   logic [LOG2N-1:0] aq [PIPE];
   logic [LOG2N-1:0] bq [PIPE];

   // next pair index and its addresses: a is j with a 0 inserted at the span bit
   always_comb begin
      nj = j;
      ns = stage;
      unique case (st)
         IDLE:    begin nj = '0; ns = '0; end
         RUN:     nj = j + JW'(1);
         DRAIN:   begin nj = '0; ns = stage + 4'd1; end
         default: ;
      endcase
      sh   = 4'(JW) - ns;
      span = ONE << sh;
      lo   = span - ONE;
      jx   = {1'b0, nj};
      na   = ((jx & ~lo) << 1) | (jx & lo);
      nb   = na | span;
      kk   = nj & lo[JW-1:0];
      ntw  = kk << ns;
   end

   // control FSM with registered read-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         stage     <= '0;
         j         <= '0;
         dcnt      <= '0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
      end else if (ce) begin
         done <= 1'b0;
         unique case (st)
            IDLE: begin
               if (start) begin
                  st        <= RUN;
                  busy      <= 1'b1;
                  rd_en     <= 1'b1;
                  j         <= nj;
                  stage     <= ns;
                  rd_addr_a <= na;
                  rd_addr_b <= nb;
                  tw_addr   <= ntw;
               end
            end
            RUN: begin
               if (j == JLAST) begin
                  st    <= DRAIN;
                  rd_en <= 1'b0;
                  dcnt  <= '0;
               end else begin
                  j         <= nj;
                  rd_addr_a <= na;
                  rd_addr_b <= nb;
                  tw_addr   <= ntw;
               end
            end
            DRAIN: begin
               if (dcnt == 3'(PIPE - 1)) begin
                  if (stage == 4'(LOG2N - 1)) begin
                     st   <= DONE;
                     busy <= 1'b0;
                     done <= 1'b1;
                  end else begin
                     st        <= RUN;
                     rd_en     <= 1'b1;
                     j         <= nj;
                     stage     <= ns;
                     rd_addr_a <= na;
                     rd_addr_b <= nb;
                     tw_addr   <= ntw;
                  end
               end else begin
                  dcnt <= dcnt + 3'd1;
               end
            end
            DONE: st <= IDLE;
         endcase
      end
   end

   // strobe/address delay line, advances only on ce cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vq <= '0;
         for (int i = 0; i < PIPE; i++) begin
            aq[i] <= '0;
            bq[i] <= '0;
         end
      end else if (ce) begin
         vq[0] <= rd_en;
         aq[0] <= rd_addr_a;
         bq[0] <= rd_addr_b;
         for (int i = 1; i < PIPE; i++) begin
            vq[i] <= vq[i-1];
            aq[i] <= aq[i-1];
            bq[i] <= bq[i-1];
         end
      end
   end

   assign wr_en     = vq[PIPE-1] & ce;
   assign wr_addr_a = aq[PIPE-1];
   assign wr_addr_b = bq[PIPE-1];

   if (RD_LAT == 0) begin : g_bce0
      assign bfly_ce = rd_en & ce;
   end else begin : g_bcen
      assign bfly_ce = vq[RD_LAT-1] & ce;
   end

endmodule

// File: tb/tb_bfly_fft_sched.sv
// tb_bfly_fft_sched: schedule model plus RAM/butterfly model checks.
// Random ce and start noise; spectra compared against a direct DFT.
module tb_bfly_fft_sched;

   localparam int LOG2N  = 3;
   localparam int RD_LAT = 1;
   localparam int BF_LAT = 1;
   localparam int N      = 1 << LOG2N;
   localparam int PIPE   = RD_LAT + BF_LAT;
   localparam int SEG    = N / 2 + PIPE;
   localparam int TOT    = LOG2N * SEG;
   localparam real PI    = 3.14159265358979;

   logic             clk = 1'b0;
   logic             rst;
   logic             ce;
   logic             start;
   logic             busy;
   logic             done;
   logic [3:0]       stage;
   logic             rd_en;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             bfly_ce;
   logic             wr_en;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;

   int n_cmp = 0;
   int n_bad = 0;
   int mm;
   real mr [N];
   real mi [N];
   real xr [N];
   real xi [N];
   int twq [$];

   bfly_fft_sched #(
      .LOG2N (LOG2N),
      .RD_LAT(RD_LAT),
      .BF_LAT(BF_LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .stage    (stage),
      .rd_en    (rd_en),
      .rd_addr_a(rd_addr_a),
      .rd_addr_b(rd_addr_b),
      .tw_addr  (tw_addr),
      .bfly_ce  (bfly_ce),
      .wr_en    (wr_en),
      .wr_addr_a(wr_addr_a),
      .wr_addr_b(wr_addr_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chkr(input string nm, input real got, input real exp);
      real d;
      n_cmp++;
      d = got - exp;
      if (d < 0.0) d = -d;
      if (d > 1.0e-6) begin
         n_bad++;
         $display("FAIL %s: got %f expected %f at %0t", nm, got, exp, $time);
      end
   endtask

   // schedule position m (1-based, in ce-cycles since start) -> read pair
   function automatic void rdpos(input int m, output bit v, output int s,
                                 output int a, output int b, output int tw);
      int j, span, k, g;
      v = 0; s = 0; a = 0; b = 0; tw = 0;
      if (m < 1 || m > TOT) return;
      s = (m - 1) / SEG;
      j = (m - 1) % SEG;
      if (j >= N / 2) return;
      v = 1;
      span = N >> (s + 1);
      k = j % span;
      g = j / span;
      a = g * 2 * span + k;
      b = a + span;
      tw = k << s;
   endfunction

   function automatic int brev(input int k);
      int r = 0;
      for (int i = 0; i < LOG2N; i++)
         r |= ((k >> i) & 1) << (LOG2N - 1 - i);
      return r;
   endfunction

   // model position: counts ce edges since the accepted start
   always @(posedge clk or posedge rst) begin
      if (rst) mm <= 0;
      else if (ce) begin
         if ((mm == 0 || mm >= TOT + 2) && start) mm <= 1;
         else if (mm >= 1 && mm <= TOT + 1) mm <= mm + 1;
      end
   end

   bit ev, evb, evw;
   int es, ea, eb, et, ds, da, db, dt, ws, wa, wb, wt;

   // cycle compare against the schedule model
   always @(negedge clk) begin
      if (!rst) begin
         rdpos(mm, ev, es, ea, eb, et);
         rdpos(mm - RD_LAT, evb, ds, da, db, dt);
         rdpos(mm - PIPE, evw, ws, wa, wb, wt);
         chk("busy", busy, 32'(mm >= 1 && mm <= TOT));
         chk("done", done, 32'(mm == TOT + 1));
         chk("rd_en", rd_en, 32'(ev));
         if (ev) begin
            chk("rd_addr_a", rd_addr_a, ea);
            chk("rd_addr_b", rd_addr_b, eb);
            chk("tw_addr", tw_addr, et);
            chk("stage", stage, es);
         end
         chk("bfly_ce", bfly_ce, 32'(evb && ce));
         chk("wr_en", wr_en, 32'(evw && ce));
         if (evw && ce) begin
            chk("wr_addr_a", wr_addr_a, wa);
            chk("wr_addr_b", wr_addr_b, wb);
         end
      end
   end

   function automatic void bf(input real ar, input real ai, input real br_, input real bi,
                              input int t, output real sr, output real si,
                              output real dr, output real di);
      real c, sn, ur, ui;
      c  = $cos(2.0 * PI * t / N);
      sn = -$sin(2.0 * PI * t / N);
      sr = (ar + br_) / 2.0;
      si = (ai + bi) / 2.0;
      ur = (ar - br_) / 2.0;
      ui = (ai - bi) / 2.0;
      dr = ur * c - ui * sn;
      di = ur * sn + ui * c;
   endfunction

   real sr, si, dr, di;
   int t;

   // frame RAM + butterfly model driven by the DUT strobes
   always @(posedge clk) begin
      if (rst) twq.delete();
      else begin
         if (rd_en && ce) twq.push_back(int'(tw_addr));
         if (wr_en && twq.size() > 0) begin
            t = twq.pop_front();
            bf(mr[wr_addr_a], mi[wr_addr_a], mr[wr_addr_b], mi[wr_addr_b],
               t, sr, si, dr, di);
            mr[wr_addr_a] = sr;
            mi[wr_addr_a] = si;
            mr[wr_addr_b] = dr;
            mi[wr_addr_b] = di;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_xfer();
      start = 1'b1;
      ce = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load(input bit impulse);
      for (int n = 0; n < N; n++) begin
         if (impulse) begin
            xr[n] = (n == 0) ? 64.0 : 0.0;
            xi[n] = 0.0;
         end else begin
            xr[n] = real'(int'($urandom_range(200)) - 100);
            xi[n] = real'(int'($urandom_range(200)) - 100);
         end
         mr[n] = xr[n];
         mi[n] = xi[n];
      end
   endtask

   task automatic check_spec(input string nm);
      real er, ei, ang;
      for (int k = 0; k < N; k++) begin
         er = 0.0;
         ei = 0.0;
         for (int n = 0; n < N; n++) begin
            ang = -2.0 * PI * n * k / N;
            er += xr[n] * $cos(ang) - xi[n] * $sin(ang);
            ei += xr[n] * $sin(ang) + xi[n] * $cos(ang);
         end
         chkr({nm, "_re"}, mr[brev(k)], er / N);
         chkr({nm, "_im"}, mi[brev(k)], ei / N);
      end
   endtask

   task automatic run_until_done(input int pce, input bit rstart);
      bit seen = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         ce = ($urandom_range(99) < pce);
         start = rstart ? ($urandom_range(9) == 0) : 1'b0;
         @(negedge clk);
         seen = done;
         tick();
      end
      start = 1'b0;
      chk("done_seen", 32'(seen), 1);
      ce = 1'b1;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ce = 1'b0;
      start = 1'b0;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_stage", stage, 0);
      chk("rst_rd_a", rd_addr_a, 0);
      chk("rst_wr_b", wr_addr_b, 0);
      chk("rst_tw", tw_addr, 0);
      tick();
      rst = 1'b0;
      ce = 1'b1;
      tick();

      // nominal run, ignored start at 5, restart at 20
      begin_xfer();
      for (int c = 1; c <= 22; c++) begin
         start = (c == 5 || c == 20);
         ce = 1'b1;
         @(negedge clk);
         case (c)
            1: begin
               chk("r1_c1_rd", rd_en, 1);
               chk("r1_c1_a", rd_addr_a, 0);
               chk("r1_c1_b", rd_addr_b, 4);
               chk("r1_c1_busy", busy, 1);
            end
            2: chk("r1_c2_bce", bfly_ce, 1);
            3: begin
               chk("r1_c3_wr", wr_en, 1);
               chk("r1_c3_wa", wr_addr_a, 0);
               chk("r1_c3_wb", wr_addr_b, 4);
            end
            4: begin
               chk("r1_c4_a", rd_addr_a, 3);
               chk("r1_c4_b", rd_addr_b, 7);
               chk("r1_c4_tw", tw_addr, 3);
            end
            5: begin
               chk("r1_c5_rd", rd_en, 0);
               chk("r1_c5_bce", bfly_ce, 1);
            end
            8: begin
               chk("r1_c8_a", rd_addr_a, 1);
               chk("r1_c8_b", rd_addr_b, 3);
               chk("r1_c8_tw", tw_addr, 2);
               chk("r1_c8_st", stage, 1);
            end
            9: begin
               chk("r1_c9_a", rd_addr_a, 4);
               chk("r1_c9_b", rd_addr_b, 6);
            end
            16: begin
               chk("r1_c16_a", rd_addr_a, 6);
               chk("r1_c16_b", rd_addr_b, 7);
               chk("r1_c16_st", stage, 2);
            end
            18: begin
               chk("r1_c18_busy", busy, 1);
               chk("r1_c18_done", done, 0);
            end
            19: begin
               chk("r1_c19_done", done, 1);
               chk("r1_c19_busy", busy, 0);
            end
            20: chk("r1_c20_done", done, 0);
            21: begin
               chk("r1_c21_rd", rd_en, 1);
               chk("r1_c21_a", rd_addr_a, 0);
               chk("r1_c21_b", rd_addr_b, 4);
               chk("r1_c21_st", stage, 0);
            end
            default: ;
         endcase
         tick();
      end
      start = 1'b0;
      run_until_done(100, 1'b0);

      // ce held low for three cycles at stage 1, j = 2
      begin_xfer();
      for (int c = 1; c <= 23; c++) begin
         ce = !(c >= 9 && c <= 11);
         @(negedge clk);
         case (c)
            9:  chk("r2_c9_a", rd_addr_a, 4);
            10: begin
               chk("r2_c10_wr", wr_en, 0);
               chk("r2_c10_bce", bfly_ce, 0);
               chk("r2_c10_a", rd_addr_a, 4);
            end
            12: begin
               chk("r2_c12_a", rd_addr_a, 4);
               chk("r2_c12_wr", wr_en, 1);
               chk("r2_c12_wa", wr_addr_a, 0);
            end
            13: chk("r2_c13_a", rd_addr_a, 5);
            21: chk("r2_c21_busy", busy, 1);
            22: chk("r2_c22_done", done, 1);
            default: ;
         endcase
         tick();
      end

      // asynchronous reset in stage 1
      begin_xfer();
      repeat (8) tick();
      @(negedge clk);
      chk("r3_pre_wr", wr_en, 1);
      #1 rst = 1'b1;
      #1;
      chk("r3_busy", busy, 0);
      chk("r3_rd", rd_en, 0);
      chk("r3_wr", wr_en, 0);
      chk("r3_bce", bfly_ce, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      begin_xfer();
      @(negedge clk);
      chk("r3_rs_rd", rd_en, 1);
      chk("r3_rs_b", rd_addr_b, 4);
      chk("r3_rs_st", stage, 0);
      tick();
      run_until_done(100, 1'b0);

      // impulse frame, then random frames, with random ce and start noise
      load(1'b1);
      begin_xfer();
      run_until_done(70, 1'b1);
      check_spec("imp");
      for (int r = 0; r < 4; r++) begin
         load(1'b0);
         begin_xfer();
         run_until_done(75, 1'b1);
         check_spec("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
